pc_stack: RTL
=============

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the PC and offset/target width in bits (legal range 4..32).
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of return-address stack entries (legal range 2..64).
REQ-003 The module SHALL have parameter RESET_VEC, default 0, meaning the PC value loaded on reset.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports as listed in REQ-005 to REQ-018.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 inc  input  1  request pc <= pc + 1.
REQ-008 add  input  1  request pc <= pc + offset.
REQ-009 sub  input  1  request pc <= pc - offset.
REQ-010 jmp  input  1  request pc <= target.
REQ-011 call  input  1  request push (pc + 1) onto the stack, then pc <= target.
REQ-012 ret  input  1  request pop the top of stack into pc.
REQ-013 offset  input  WIDTH  unsigned relative displacement for add/sub.
REQ-014 target  input  WIDTH  absolute destination for jmp/call.
REQ-015 pc  output  WIDTH  current program counter, registered.
REQ-016 depth  output  $clog2(DEPTH+1)  number of valid stack entries, registered.
REQ-017 overflow  output  1  sticky flag: a call was attempted while the stack was full.
REQ-018 underflow  output  1  sticky flag: a ret was attempted while the stack was empty.

Function
REQ-019 All outputs SHALL change only on a rising clk edge, so a request sampled at edge N is visible on pc and depth after edge N (1-cycle latency).
REQ-020 When several requests are high together, exactly one SHALL execute, by fixed priority ret > call > jmp > sub > add > inc; all lower-priority requests are ignored.
REQ-021 With no request high, pc, depth and the stack contents SHALL hold.
REQ-022 All pc arithmetic SHALL be modulo 2^WIDTH: wrap-around on add/inc and borrow-wrap on sub, with no carry or borrow output.
REQ-023 sub SHALL compute pc + ~offset + 1 (two's complement), and add SHALL compute pc + offset.
REQ-024 call with depth < DEPTH SHALL write (pc + 1) mod 2^WIDTH to entry [depth], increment depth, and load pc with target.
REQ-025 call with depth == DEPTH SHALL leave pc, depth and the stack unchanged and set overflow.
REQ-026 ret with depth > 0 SHALL load pc with entry [depth-1] and decrement depth.
REQ-027 ret with depth == 0 SHALL leave pc and depth unchanged and set underflow.
REQ-028 overflow and underflow SHALL remain set until reset, and SHALL NOT block later operations.
REQ-029 The stack SHALL be LIFO, so entries below the top are never modified by a push or a pop.
REQ-030 jmp, add, sub and inc SHALL NOT change depth or the stack.

Reset
REQ-031 On reset at a rising edge, the module SHALL set pc = RESET_VEC, depth = 0, overflow = 0 and underflow = 0.
REQ-032 Reset SHALL take priority over every request in the same cycle, including a call or ret in progress.
REQ-033 Stack entry contents need not be cleared on reset, because they are unreachable while depth = 0.

Verification (WIDTH=16, DEPTH=4, RESET_VEC=16'h0100 unless stated)
REQ-034 Reset then 3 inc cycles -> pc = 0x0100, 0x0101, 0x0102, 0x0103 on successive cycles; depth = 0.
REQ-035 pc=0xFFFE, add with offset=3 -> pc = 0x0001; then sub with offset=2 -> pc = 0xFFFF.
REQ-036 The bench SHALL check call/ret nesting:
- pc=0x0100, call target=0x2000 -> pc = 0x2000, depth = 1.
- call target=0x3000 -> pc = 0x3000, depth = 2.
- ret -> pc = 0x2001, depth = 1.
- ret -> pc = 0x0101, depth = 0.
REQ-037 The bench SHALL check stack limits:
- 5 consecutive calls -> depth = 4 after the 4th call.
- The 5th call leaves pc unchanged and sets overflow = 1.
- 5 rets then return through the 4 entries and set underflow = 1; both flags stay 1.
REQ-038 inc=add=jmp=1 together with target=0x0400, offset=0x0010 -> pc = 0x0400 (jmp wins); ret=call=1 with depth=0 -> underflow = 1 and pc unchanged.
REQ-039 Assert reset in the same cycle as call, with depth = 2 -> pc = 0x0100, depth = 0, both flags 0.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a return-address stack for call/ret.
// Latency: every request takes effect on the next rising clk edge.
// Backpressure: none; a call on a full stack or a ret on an empty one is dropped and flagged.
module pc_stack #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc,
    input  logic                         add,
    input  logic                         sub,
    input  logic                         jmp,
    input  logic                         call,
    input  logic                         ret,
    input  logic [WIDTH-1:0]             offset,
    input  logic [WIDTH-1:0]             target,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic             full;
    logic             empty;
    logic             push;
    logic [DW-1:0]    depth_dec;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_add;
    logic [WIDTH-1:0] pc_sub;

    assign full      = (depth == DW'(DEPTH));
    assign empty     = (depth == '0);
    assign depth_dec = depth - DW'(1);
    assign pc_inc    = pc + WIDTH'(1);
    assign pc_add    = pc + offset;
    assign pc_sub    = pc + ~offset + WIDTH'(1);

    // Only a call that actually wins arbitration may write the stack.
    assign push = !reset && !ret && call && !full;

    // Entries are not reset; they are unreachable until pushed again.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[depth[AW-1:0]] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_VEC;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (ret) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                pc    <= stack_mem[depth_dec[AW-1:0]];
                depth <= depth_dec;
            end
        end else if (call) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                pc    <= target;
                depth <= depth + DW'(1);
            end
        end else if (jmp) begin
            pc <= target;
        end else if (sub) begin
            pc <= pc_sub;
        end else if (add) begin
            pc <= pc_add;
        end else if (inc) begin
            pc <= pc_inc;
        end
    end

endmodule
